// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB LED sequencer: display modes, chase colours and
// breathe direction.
package rgb_led_pkg;

  typedef enum logic [1:0] {
    COUNT   = 2'd0,
    CHASE   = 2'd1,
    BREATHE = 2'd2,
    OFF     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  function automatic color_e next_color(input color_e c);
    case (c)
      RED:     return GREEN;
      GREEN:   return BLUE;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..PERIOD-1 and raises tick for the single
// cycle in which the count sits at PERIOD-1.
module tick_gen #(
  parameter int PERIOD = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/rgb_led_seq.sv
// N-LED RGB driver with PWM brightness and four display modes (binary count,
// colour chase, breathe, off). LED pins are registered.
module rgb_led_seq
  import rgb_led_pkg::*;
#(
  parameter int N_LEDS         = 4,
  parameter int PWM_BITS       = 8,
  parameter int STEP_CYCLES    = 20_000_000,
  parameter int BREATHE_CYCLES = 100_000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  output logic [N_LEDS-1:0]   led_r,
  output logic [N_LEDS-1:0]   led_g,
  output logic [N_LEDS-1:0]   led_b,
  output logic                step_tick
);

  localparam int PTN_W = 3 * N_LEDS;
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  mode_e mode_sel;
  logic  btick;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PTN_W-1:0]    ptn, ptn_d;
  logic [POS_W-1:0]    pos, pos_d;
  color_e              color, color_d;
  logic [PWM_BITS-1:0] level, level_d;
  dir_e                dir, dir_d;

  logic [N_LEDS-1:0]   lit_r, lit_g, lit_b;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_on;

  assign mode_sel = mode_e'(mode);

  tick_gen #(.PERIOD(STEP_CYCLES)) u_step_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (step_tick)
  );

  tick_gen #(.PERIOD(BREATHE_CYCLES)) u_breathe_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (btick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt <= '0;
      ptn     <= '0;
      pos     <= '0;
      color   <= RED;
      level   <= '0;
      dir     <= UP;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      ptn     <= ptn_d;
      pos     <= pos_d;
      color   <= color_d;
      level   <= level_d;
      dir     <= dir_d;
    end
  end

  // Only the selected mode advances; every other mode's state is held so it
  // resumes where it left off.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can infer a latch.
    ptn_d   = ptn;
    pos_d   = pos;
    color_d = color;
    level_d = level;
    dir_d   = dir;
    case (mode_sel)
      COUNT: begin
        if (step_tick) ptn_d = ptn + PTN_W'(1);
      end
      CHASE: begin
        if (step_tick) begin
          if (pos == POS_LAST) begin
            pos_d   = '0;
            color_d = next_color(color);
          end else begin
            pos_d = pos + POS_W'(1);
          end
        end
      end
      BREATHE: begin
        // Turn around on the same tick that hits an end, so each end value
        // is shown for one breathe period only.
        if (btick) begin
          if (dir == UP) begin
            if (level == LEVEL_MAX) begin
              dir_d   = DOWN;
              level_d = level - PWM_BITS'(1);
            end else begin
              level_d = level + PWM_BITS'(1);
            end
          end else begin
            if (level == '0) begin
              dir_d   = UP;
              level_d = PWM_BITS'(1);
            end else begin
              level_d = level - PWM_BITS'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    lit_r = '0;
    lit_g = '0;
    lit_b = '0;
    duty  = '0;
    case (mode_sel)
      COUNT: begin
        lit_r = ptn[3*N_LEDS-1 -: N_LEDS];
        lit_g = ptn[2*N_LEDS-1 -: N_LEDS];
        lit_b = ptn[N_LEDS-1:0];
        duty  = bright;
      end
      CHASE: begin
        duty = bright;
        case (color)
          RED:     lit_r[pos] = 1'b1;
          GREEN:   lit_g[pos] = 1'b1;
          default: lit_b[pos] = 1'b1;
        endcase
      end
      BREATHE: begin
        lit_r = '1;
        lit_g = '1;
        lit_b = '1;
        duty  = level;
      end
      default: ;
    endcase
  end

  assign pwm_on = (pwm_cnt < duty);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_r <= '0;
      led_g <= '0;
      led_b <= '0;
    end else begin
      led_r <= lit_r & {N_LEDS{pwm_on}};
      led_g <= lit_g & {N_LEDS{pwm_on}};
      led_b <= lit_b & {N_LEDS{pwm_on}};
    end
  end

endmodule

// File: doc/rgb_led_seq.md
Name: rgb_led_seq

Overview:
- Parametrised driver for N on-board RGB LEDs with per-channel PWM brightness and four display modes: binary count, colour chase, breathe, off.
- Sits directly behind the top-level LED pins. Control inputs come from switches/buttons or a control register.
- Replaces the fixed full-brightness counting pattern generator.

Parameters:
- N_LEDS, 4, number of RGB LEDs (>=1).
- PWM_BITS, 8, PWM counter/duty width; PWM period = 2^PWM_BITS cycles.
- STEP_CYCLES, 20_000_000, clock cycles per pattern step (count/chase modes), >=2.
- BREATHE_CYCLES, 100_000, clock cycles per breathe level step, >=2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- mode  in  2  0=COUNT, 1=CHASE, 2=BREATHE, 3=OFF; sampled every cycle.
- bright  in  PWM_BITS  duty for lit channels in COUNT/CHASE.
- led_r  out  N_LEDS  red drive, bit i = LED i, 1 = on.
- led_g  out  N_LEDS  green drive.
- led_b  out  N_LEDS  blue drive.
- step_tick  out  1  one-cycle pulse on each pattern step.

Behaviour:
- Reset: all outputs 0 and all state cleared. This means ptn=0, pos=0, color=RED, level=0, dir=UP, all counters 0.
- Step prescaler: counts 0..STEP_CYCLES-1 and wraps. step_tick=1 in the cycle count==STEP_CYCLES-1, so the first tick comes STEP_CYCLES cycles after reset release. It free-runs in every mode, including OFF.
- Breathe prescaler: identical structure with BREATHE_CYCLES; internal btick.
- PWM counter: PWM_BITS wide, free-running, wraps 2^PWM_BITS-1 -> 0.
- Channel on condition: lit && (pwm_cnt < duty), unsigned. Duty 0 means never on. Duty 2^PWM_BITS-1 means on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- LED outputs are registered: one cycle latency from compare to pin.
- COUNT: ptn is 3*N_LEDS bits and is incremented on step_tick, modulo 2^(3*N_LEDS).
  - ptn[3N-1:2N] = red, [2N-1:N] = green, [N-1:0] = blue; bit i of each group drives LED i.
  - duty = bright.
- CHASE: exactly one channel lit, LED pos in colour color, duty = bright.
  - On step_tick pos increments.
  - When pos wraps N_LEDS-1 -> 0, color advances RED -> GREEN -> BLUE -> RED in the same tick.
- BREATHE: all 3*N_LEDS channels lit, duty = level.
  - On btick level moves ±1 as a triangle wave.
  - At 2^PWM_BITS-1 with dir UP: dir becomes DOWN and level becomes max-1 on that tick. Mirror behaviour at 0 with dir DOWN.
  - The turn-around value is held for exactly one btick period (no double dwell).
- OFF: all LED outputs 0 one cycle after mode=3 is sampled.
- State per mode is updated only while that mode is selected. All other state is held.
  - Prescalers and PWM counter never reset on a mode change.
  - Returning to a mode resumes its held state.
- Mode change takes effect on the next registered output (1 cycle). A tick coinciding with a mode change applies to the newly selected mode.
- bright changes take effect on the next compare; no glitch filtering required.
- Async RST mid-operation: outputs go to 0 immediately, without waiting for a clock edge. Operation restarts as from power-up after release.

Decomposition:
- Package rgb_led_pkg:
  - mode_e enum {COUNT, CHASE, BREATHE, OFF} (2 bits).
  - color_e enum {RED, GREEN, BLUE}.
  - dir_e enum {UP, DOWN}.
- Sub-module tick_gen #(PERIOD) (CLK, RST, tick): instantiated twice, once for step and once for breathe.
- PWM compare and mode logic stay in rgb_led_seq.

Test Plan (N_LEDS=4, PWM_BITS=3, STEP_CYCLES=4, BREATHE_CYCLES=2):
- Reset release, mode=0, bright=7: first step_tick at cycle 4; ptn=1 gives led_b[0] high 7 of 8 cycles, other outputs 0. After 4096 ticks ptn wraps to 0 and all outputs stay 0.
- mode=0 with ptn bit set, bright=3: output high exactly 3 of every 8 cycles, phase pwm_cnt 0..2, one cycle delayed. With bright=0 the output is never high.
- mode=1, bright=7: lit channel sequence r0,r1,r2,r3,g0..g3,b0..b3, back to r0 after 12 ticks; never more than one bit set.
- mode=2: level sequence per btick 0,1,..,7,6,..,0,1. Each led_* bit high for level cycles per 8-cycle PWM period.
- Count in mode 0 to ptn=5, switch to mode=3: all outputs 0 next cycle. Hold 10 cycles, return to mode 0: ptn resumes at 5.
- Assert RST between clock edges mid-CHASE: outputs 0 immediately. After release, step_tick again first at cycle 4 and chase restarts at r0.
